// File: rtl/encoder_715.sv
// encoder_715: serial systematic (15,7) cyclic encoder, g(x)=1+x^4+x^6+x^7+x^8, valid/ready on both sides.
// Optional ENC_ERR_INJECT_EN adds err_mask, XORed onto the codeword to emit known error patterns.
module encoder_715 #(
  parameter int K = 7,
  parameter int N = 15,
  parameter logic [7:0] GPOLY = 8'hD1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [K-1:0] msg,
  input  logic         msg_valid,
  output logic         msg_ready,
`ifdef ENC_ERR_INJECT_EN
  input  logic [N-1:0] err_mask,
`endif
  output logic [N-1:0] cw,
  output logic         cw_valid,
  input  logic         cw_ready
);
  if (K != 7 || N != 15) begin : g_bad_size
    $error("encoder_715 supports only K=7, N=15");
  end
  typedef enum logic [1:0] {IDLE, ENCODE, DONE} state_t;
  state_t state, state_n;
  logic [K-1:0] sr;
  logic [7:0] p, p_n;
  logic [2:0] cnt;
`ifdef ENC_ERR_INJECT_EN
  logic [N-1:0] mask;
`endif
  always_comb begin
    state_n = state;
    p_n = {p[6:0], 1'b0} ^ ((sr[K-1] ^ p[7]) ? GPOLY : 8'h00);
    case (state)
      IDLE:    state_n = msg_valid ? ENCODE : IDLE;
      ENCODE:  state_n = (cnt == 3'd6) ? DONE : ENCODE;
      DONE:    state_n = cw_ready ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
  end
  assign msg_ready = (state == IDLE);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cw_valid <= 1'b0;
      cw <= '0;
      p <= '0;
      cnt <= '0;
      sr <= '0;
`ifdef ENC_ERR_INJECT_EN
      mask <= '0;
`endif
    end else begin
      state <= state_n;
      if (state == IDLE && msg_valid) begin
        sr <= msg;
        cw[N-1:8] <= msg;
        p <= '0;
        cnt <= '0;
`ifdef ENC_ERR_INJECT_EN
        mask <= err_mask;
`endif
      end else if (state == ENCODE) begin
        p <= p_n;
        sr <= {sr[K-2:0], 1'b0};
        cnt <= cnt + 3'd1;
        if (cnt == 3'd6) begin
          cw_valid <= 1'b1;
`ifdef ENC_ERR_INJECT_EN
          cw <= {cw[N-1:8], p_n} ^ mask;
`else
          cw <= {cw[N-1:8], p_n};
`endif
        end
      end else if (state == DONE && cw_ready) begin
        cw_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_encoder_715.sv
// tb_encoder_715: scoreboard bench for encoder_715; expected codewords from hand-computed parity columns.
module tb_encoder_715;
  logic clk = 0;
  logic rst = 1;
  logic [6:0] msg = '0;
  logic msg_valid = 0;
  logic msg_ready;
  logic [14:0] cw;
  logic cw_valid;
  logic cw_ready = 0;
`ifdef ENC_ERR_INJECT_EN
  logic [14:0] err_mask = '0;
`endif
  int vectors = 0;
  int miscompares = 0;
  logic [14:0] sb [$];
  logic [7:0] col [7] = '{8'hD1, 8'h73, 8'hE6, 8'h1D, 8'h3A, 8'h74, 8'hE8};

  encoder_715 dut (
    .clk(clk), .rst(rst), .msg(msg), .msg_valid(msg_valid), .msg_ready(msg_ready),
`ifdef ENC_ERR_INJECT_EN
    .err_mask(err_mask),
`endif
    .cw(cw), .cw_valid(cw_valid), .cw_ready(cw_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [14:0] exp_cw(input logic [6:0] m);
    logic [7:0] q = '0;
    for (int j = 0; j < 7; j++) if (m[j]) q ^= col[j];
    return {m, q};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && cw_valid && cw_ready) begin
      if (sb.size() == 0) chk("unexpected_cw", {17'd0, cw}, 32'hFFFF_FFFF);
      else chk("cw", {17'd0, cw}, {17'd0, sb.pop_front()});
    end
  end

  task automatic send(input logic [6:0] m, input logic [14:0] e);
    int t = 0;
    while (!msg_ready && t < 200) begin @(posedge clk); #1; t++; end
    if (!msg_ready) chk("send_timeout", 32'(msg_ready), 32'd1);
    msg = m;
    msg_valid = 1;
`ifdef ENC_ERR_INJECT_EN
    err_mask = e;
`endif
    sb.push_back(exp_cw(m) ^ e);
    @(posedge clk); #1;
    msg_valid = 0;
  endtask

  initial begin
    logic [14:0] snap;
    int first, nvalid, t;
    logic stable;
    // reset with a message offered that must not be taken
    msg = 7'h55; msg_valid = 1;
    @(posedge clk); @(posedge clk); #1;
    rst = 0; msg_valid = 0;
    chk("rst_cw_valid", 32'(cw_valid), 32'd0);
    chk("rst_cw", {17'd0, cw}, 32'd0);
    chk("rst_msg_ready", 32'(msg_ready), 32'd1);
    @(posedge clk); #1;
    chk("rst_no_accept", 32'(msg_ready), 32'd1);
    // latency and pulse width
    cw_ready = 1;
    msg = 7'h01; msg_valid = 1; sb.push_back(15'h01D1);
    @(posedge clk); #1; msg_valid = 0;
    first = 0; nvalid = 0;
    for (int i = 1; i <= 9; i++) begin
      @(posedge clk); #1;
      if (cw_valid) begin nvalid++; if (first == 0) first = i; end
    end
    chk("latency", 32'(first), 32'd7);
    chk("pulse_width", 32'(nvalid), 32'd1);
    // backpressure
    cw_ready = 0;
    send(7'h40, 15'h0);
    t = 0;
    while (!cw_valid && t < 50) begin @(posedge clk); #1; t++; end
    chk("bp_valid", 32'(cw_valid), 32'd1);
    snap = cw; stable = 1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (cw !== snap || !cw_valid || msg_ready) stable = 0;
    end
    chk("bp_stable", 32'(stable), 32'd1);
    chk("bp_value", {17'd0, snap}, 32'h40E8);
    cw_ready = 1;
    @(posedge clk); #1;
    chk("bp_release_ready", 32'(msg_ready), 32'd1);
    chk("bp_release_valid", 32'(cw_valid), 32'd0);
    // reset on the 4th ENCODE edge discards the partial codeword
    msg = 7'h7F; msg_valid = 1;
    @(posedge clk); #1; msg_valid = 0;
    @(posedge clk); @(posedge clk); @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    stable = 1;
    for (int i = 0; i < 10; i++) begin
      if (cw_valid || !msg_ready) stable = 0;
      @(posedge clk); #1;
    end
    chk("midrst_quiet", 32'(stable), 32'd1);
    send(7'h01, 15'h0);
    // hand-computed vectors, then every message back to back
    send(7'h7F, 15'h0);
    send(7'h00, 15'h0);
    send(7'h40, 15'h0);
    for (int m = 0; m < 128; m++) send(7'(m), 15'h0);
`ifdef ENC_ERR_INJECT_EN
    send(7'h01, 15'h0004);
`endif
    t = 0;
    while (sb.size() != 0 && t < 100) begin @(posedge clk); #1; t++; end
    chk("drain", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
